// File: rtl/sd_data_phys.sv
// sd_data_phys: DAT0 line serializer/deserializer for one SD data block (start bit, data, CRC16, end bit).
// Latency: TX start bit is on the line the cycle after Send; each RX word is pushed 1 cycle after its last bit; Complete 1 cycle after the end bit.
// Backpressure: TX pops only while FIFO_ok and aborts with Underrun otherwise; RX has none, so the RX FIFO must hold a whole block.
//
// Ports:
//   SD_clock, Reset        - clock (rising edge) and asynchronous active-low reset
//   WriteRead, Send, Idle  - transfer direction, block start request, synchronous abort
//   Timeout_enable/_reg    - read start-bit timeout control, in SD_clock cycles
//   Data_from_FIFO/FIFO_ok - show-ahead TX FIFO head; Fifo_read pops it
//   Data_to_FIFO/Fifo_write- received word and its one-cycle push strobe
//   Data_pin_in/out, Data_oe - DAT0 pad
//   Serial_ready, Complete, Timeout, Crc_error, Underrun - status back to data control
module sd_data_phys #(
    parameter int WORDS = 128,
    parameter int CNT_W = 16
) (
    input  logic             SD_clock,
    input  logic             Reset,
    input  logic             WriteRead,
    input  logic             Send,
    input  logic             Idle,
    input  logic             Timeout_enable,
    input  logic [CNT_W-1:0] Timeout_reg,
    input  logic [31:0]      Data_from_FIFO,
    input  logic             FIFO_ok,
    input  logic             Data_pin_in,
    output logic             Data_pin_out,
    output logic             Data_oe,
    output logic             Fifo_read,
    output logic [31:0]      Data_to_FIFO,
    output logic             Fifo_write,
    output logic             Serial_ready,
    output logic             Complete,
    output logic             Timeout,
    output logic             Crc_error,
    output logic             Underrun
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TX_START = 4'd1;
    localparam logic [3:0] S_TX_DATA  = 4'd2;
    localparam logic [3:0] S_TX_CRC   = 4'd3;
    localparam logic [3:0] S_TX_END   = 4'd4;
    localparam logic [3:0] S_RX_WAIT  = 4'd5;
    localparam logic [3:0] S_RX_DATA  = 4'd6;
    localparam logic [3:0] S_RX_CRC   = 4'd7;
    localparam logic [3:0] S_RX_END   = 4'd8;

    localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);

    logic [3:0]       state;
    logic [4:0]       bit_cnt;
    logic [7:0]       word_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      shift;
    logic [15:0]      crc;

    logic word_end;
    logic last_word;
    logic tx_refill;
    logic tx_active;

    // One serial step of CRC16-CCITT (0x1021), MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign word_end  = (bit_cnt == 5'd31);
    assign last_word = (word_cnt == LAST_WORD);
    // Cycles in which the next TX word must come from the FIFO: the start
    // bit cycle loads word 0, the last bit of every non-final word loads the next.
    assign tx_refill = (state == S_TX_START) ||
                       ((state == S_TX_DATA) && word_end && !last_word);
    assign tx_active = (state == S_TX_START) || (state == S_TX_DATA) ||
                       (state == S_TX_CRC)   || (state == S_TX_END);

    // Pops, underrun and timeout act in the cycle the condition is seen so
    // the FIFO pop coincides with the shift-register load.
    assign Fifo_read    = !Idle && tx_refill && FIFO_ok;
    assign Underrun     = !Idle && tx_refill && !FIFO_ok;
    assign Timeout      = !Idle && (state == S_RX_WAIT) && Data_pin_in &&
                          Timeout_enable && (wait_cnt == Timeout_reg);
    assign Serial_ready = (state == S_IDLE);
    // Abort releases the pad immediately rather than a cycle later.
    assign Data_oe      = tx_active && !Idle;

    always_comb begin
        Data_pin_out = 1'b1;
        if (!Idle) begin
            case (state)
                S_TX_START: Data_pin_out = 1'b0;
                S_TX_DATA:  Data_pin_out = shift[31];
                S_TX_CRC:   Data_pin_out = crc[15];
                default:    Data_pin_out = 1'b1;
            endcase
        end
    end

    always_ff @(posedge SD_clock or negedge Reset) begin
        if (!Reset) begin
            state        <= S_IDLE;
            bit_cnt      <= 5'd0;
            word_cnt     <= 8'd0;
            wait_cnt     <= '0;
            shift        <= 32'd0;
            crc          <= 16'd0;
            Data_to_FIFO <= 32'd0;
            Fifo_write   <= 1'b0;
            Complete     <= 1'b0;
            Crc_error    <= 1'b0;
        end else begin
            Fifo_write <= 1'b0;
            Complete   <= 1'b0;
            Crc_error  <= 1'b0;
            if (Idle) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Send) begin
                            bit_cnt  <= 5'd0;
                            word_cnt <= 8'd0;
                            wait_cnt <= '0;
                            crc      <= 16'd0;
                            state    <= WriteRead ? S_TX_START : S_RX_WAIT;
                        end
                    end
                    S_TX_START: begin
                        if (FIFO_ok) begin
                            shift <= Data_from_FIFO;
                            state <= S_TX_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_TX_DATA: begin
                        crc     <= crc_step(crc, shift[31]);
                        shift   <= {shift[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;  // wraps 31 -> 0 at the word boundary
                        if (word_end) begin
                            if (last_word) begin
                                state <= S_TX_CRC;
                            end else if (FIFO_ok) begin
                                shift    <= Data_from_FIFO;
                                word_cnt <= word_cnt + 8'd1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_TX_CRC: begin
                        crc     <= {crc[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            bit_cnt <= 5'd0;
                            state   <= S_TX_END;
                        end
                    end
                    S_TX_END: begin
                        Complete <= 1'b1;
                        state    <= S_IDLE;
                    end
                    S_RX_WAIT: begin
                        // The start bit takes precedence over a coincident timeout.
                        if (!Data_pin_in) begin
                            state <= S_RX_DATA;
                        end else if (Timeout_enable && (wait_cnt == Timeout_reg)) begin
                            state <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    S_RX_DATA: begin
                        shift   <= {shift[30:0], Data_pin_in};
                        crc     <= crc_step(crc, Data_pin_in);
                        bit_cnt <= bit_cnt + 5'd1;
                        if (word_end) begin
                            Data_to_FIFO <= {shift[30:0], Data_pin_in};
                            Fifo_write   <= 1'b1;
                            word_cnt     <= word_cnt + 8'd1;
                            if (last_word) begin
                                state <= S_RX_CRC;
                            end
                        end
                    end
                    S_RX_CRC: begin
                        // Received CRC collects in the low half of the shift register;
                        // the computed CRC is frozen while it arrives.
                        shift   <= {shift[30:0], Data_pin_in};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            bit_cnt <= 5'd0;
                            state   <= S_RX_END;
                        end
                    end
                    S_RX_END: begin
                        Complete  <= 1'b1;
                        Crc_error <= (shift[15:0] != crc) || !Data_pin_in;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_phys.sv
module tb_sd_data_phys;

    logic        clk = 1'b0;
    logic        rst_n, write_read, send, idle, to_en, fifo_ok, pin_in;
    logic [15:0] to_reg;
    logic [31:0] fifo_dat;
    logic        sel;

    logic        a_pin, a_oe, a_rd, a_fw, a_sr, a_comp, a_to, a_err, a_und;
    logic        b_pin, b_oe, b_rd, b_fw, b_sr, b_comp, b_to, b_err, b_und;
    logic [31:0] a_dto, b_dto;

    logic        s_pin, s_oe, s_rd, s_fw, s_sr, s_comp, s_to, s_err, s_und;
    logic [31:0] s_dto;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sd_data_phys #(.WORDS(1), .CNT_W(16)) u_a (
        .SD_clock(clk), .Reset(rst_n), .WriteRead(write_read), .Send(send), .Idle(idle),
        .Timeout_enable(to_en), .Timeout_reg(to_reg), .Data_from_FIFO(fifo_dat), .FIFO_ok(fifo_ok),
        .Data_pin_in(pin_in), .Data_pin_out(a_pin), .Data_oe(a_oe), .Fifo_read(a_rd),
        .Data_to_FIFO(a_dto), .Fifo_write(a_fw), .Serial_ready(a_sr), .Complete(a_comp),
        .Timeout(a_to), .Crc_error(a_err), .Underrun(a_und)
    );

    sd_data_phys #(.WORDS(2), .CNT_W(16)) u_b (
        .SD_clock(clk), .Reset(rst_n), .WriteRead(write_read), .Send(send), .Idle(idle),
        .Timeout_enable(to_en), .Timeout_reg(to_reg), .Data_from_FIFO(fifo_dat), .FIFO_ok(fifo_ok),
        .Data_pin_in(pin_in), .Data_pin_out(b_pin), .Data_oe(b_oe), .Fifo_read(b_rd),
        .Data_to_FIFO(b_dto), .Fifo_write(b_fw), .Serial_ready(b_sr), .Complete(b_comp),
        .Timeout(b_to), .Crc_error(b_err), .Underrun(b_und)
    );

    assign s_pin  = sel ? b_pin  : a_pin;
    assign s_oe   = sel ? b_oe   : a_oe;
    assign s_rd   = sel ? b_rd   : a_rd;
    assign s_fw   = sel ? b_fw   : a_fw;
    assign s_sr   = sel ? b_sr   : a_sr;
    assign s_comp = sel ? b_comp : a_comp;
    assign s_to   = sel ? b_to   : a_to;
    assign s_err  = sel ? b_err  : a_err;
    assign s_und  = sel ? b_und  : a_und;
    assign s_dto  = sel ? b_dto  : a_dto;

    typedef struct {
        logic        wr;
        logic        wide;     // 0: WORDS=1 instance, 1: WORDS=2 instance
        logic [31:0] w0;
        logic [31:0] w1;
        logic        drop;     // TX: FIFO empty before the second word
        logic        flip;     // RX: last CRC bit inverted
        logic        endb;     // RX: end bit driven by the card
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1 (long division).
    function automatic logic [15:0] crc_model(input logic [63:0] dat, input int nbits);
        logic [79:0] r;
        logic [16:0] g;
        g = 17'h11021;
        r = '0;
        for (int i = 0; i < nbits; i++) r[79-i] = dat[nbits-1-i];
        for (int i = 0; i < nbits; i++)
            if (r[79-i])
                for (int j = 0; j < 17; j++) r[79-i-j] = r[79-i-j] ^ g[16-j];
        return r[79-nbits -: 16];
    endfunction

    task automatic prep();
        idle = 1'b1; send = 1'b0; pin_in = 1'b1; to_en = 1'b0; fifo_ok = 1'b0;
        @(posedge clk); #1;
        idle = 1'b0;
    endtask

    task automatic run_tx(input int n, input vec_t v);
        int nw, len, explen, pops, n_oe, n_sr, n_comp, n_und, comp_i, und_i, last_oe;
        logic [127:0] got, expv;
        logic [15:0]  c;
        logic         sr_at_comp;
        logic         q[$];
        nw = v.wide ? 2 : 1;
        len = 32 * nw + 18;
        explen = v.drop ? 33 : len;
        c = crc_model(v.wide ? {v.w0, v.w1} : {32'h0, v.w0}, 32 * nw);
        q.push_back(1'b0);
        for (int b = 31; b >= 0; b--) q.push_back(v.w0[b]);
        if (v.wide) for (int b = 31; b >= 0; b--) q.push_back(v.w1[b]);
        for (int b = 15; b >= 0; b--) q.push_back(c[b]);
        q.push_back(1'b1);
        expv = '0;
        for (int i = 0; i < explen; i++) expv = {expv[126:0], q[i]};
        got = '0; pops = 0; n_oe = 0; n_sr = 0; n_comp = 0; n_und = 0;
        comp_i = -1; und_i = -1; last_oe = -1; sr_at_comp = 1'b0;

        prep();
        sel = v.wide; write_read = 1'b1; fifo_dat = v.w0; fifo_ok = 1'b1; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        for (int i = 0; i < len + 4; i++) begin
            fifo_dat = (pops == 0) ? v.w0 : v.w1;
            fifo_ok  = !(v.drop && pops >= 1);
            @(negedge clk);
            if (s_oe) begin
                got = {got[126:0], s_pin};
                n_oe++;
                last_oe = i;
                if (s_sr) n_sr++;
            end
            if (s_rd) pops++;
            if (s_und) begin n_und++; und_i = i; end
            if (s_comp) begin n_comp++; comp_i = i; sr_at_comp = s_sr; end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_oe_cycles", n), n_oe, explen);
        chk($sformatf("v%0d_stream", n), got, expv);
        chk($sformatf("v%0d_fifo_reads", n), pops, v.drop ? 1 : nw);
        chk($sformatf("v%0d_ready_while_busy", n), n_sr, 0);
        if (v.drop) begin
            chk($sformatf("v%0d_underrun_cnt", n), n_und, 1);
            chk($sformatf("v%0d_underrun_cycle", n), und_i, 32);
            chk($sformatf("v%0d_last_oe_cycle", n), last_oe, 32);
            chk($sformatf("v%0d_no_complete", n), n_comp, 0);
        end else begin
            chk($sformatf("v%0d_complete_cnt", n), n_comp, 1);
            chk($sformatf("v%0d_complete_cycle", n), comp_i, len);
            chk($sformatf("v%0d_no_underrun", n), n_und, 0);
            chk($sformatf("v%0d_ready_at_complete", n), sr_at_comp, 1'b1);
        end
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", n), s_sr, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic run_rx(input int n, input vec_t v);
        int nw, len, nfw, fw_i, n_comp, comp_i, n_err, n_oe;
        logic [31:0] got0, got1;
        logic [15:0] c;
        logic        err_at;
        logic        q[$];
        nw = v.wide ? 2 : 1;
        c = crc_model(v.wide ? {v.w0, v.w1} : {32'h0, v.w0}, 32 * nw);
        if (v.flip) c[0] = ~c[0];
        q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b1); q.push_back(1'b0);
        for (int b = 31; b >= 0; b--) q.push_back(v.w0[b]);
        if (v.wide) for (int b = 31; b >= 0; b--) q.push_back(v.w1[b]);
        for (int b = 15; b >= 0; b--) q.push_back(c[b]);
        q.push_back(v.endb);
        len = q.size();
        nfw = 0; fw_i = -1; n_comp = 0; comp_i = -1; n_err = 0; n_oe = 0;
        got0 = '0; got1 = '0; err_at = 1'b0;

        prep();
        sel = v.wide; write_read = 1'b0; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        for (int i = 0; i < len + 4; i++) begin
            pin_in = (i < len) ? q[i] : 1'b1;
            @(negedge clk);
            if (s_oe) n_oe++;
            if (s_fw) begin
                if (nfw == 0) begin got0 = s_dto; fw_i = i; end
                else got1 = s_dto;
                nfw++;
            end
            if (s_comp) begin n_comp++; comp_i = i; err_at = s_err; end
            if (s_err) n_err++;
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_fifo_writes", n), nfw, nw);
        chk($sformatf("v%0d_word0", n), got0, v.w0);
        chk($sformatf("v%0d_word0_cycle", n), fw_i, 36);
        if (v.wide) chk($sformatf("v%0d_word1", n), got1, v.w1);
        chk($sformatf("v%0d_complete_cnt", n), n_comp, 1);
        chk($sformatf("v%0d_complete_cycle", n), comp_i, len);
        chk($sformatf("v%0d_crc_err_at_complete", n), err_at, v.exp_err);
        chk($sformatf("v%0d_crc_err_cnt", n), n_err, v.exp_err ? 1 : 0);
        chk($sformatf("v%0d_oe_low", n), n_oe, 0);
    endtask

    initial begin
        int   to_i, n_to, n_comp;
        logic r0, r1, r2;

        rst_n = 1'b0; write_read = 1'b0; send = 1'b0; idle = 1'b0; to_en = 1'b0;
        fifo_ok = 1'b0; pin_in = 1'b1; to_reg = 16'd0; fifo_dat = 32'd0; sel = 1'b0;

        // Reset state
        #12;
        chk("rst_oe", {a_oe, b_oe}, 2'b00);
        chk("rst_pin", {a_pin, b_pin}, 2'b11);
        chk("rst_ready", {a_sr, b_sr}, 2'b11);
        chk("rst_dto", {a_dto, b_dto}, 64'h0);
        chk("rst_pulses", {a_rd, a_fw, a_comp, a_to, a_err, a_und, b_rd, b_fw, b_comp, b_to, b_err, b_und}, 12'h000);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0] = '{1'b1, 1'b0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b1, 1'b1};

        for (int n = 0; n < 9; n++) begin
            if (vecs[n].wr) run_tx(n, vecs[n]);
            else run_rx(n, vecs[n]);
        end

        // Send during Idle is ignored
        prep();
        sel = 1'b0; idle = 1'b1; send = 1'b1; write_read = 1'b1; fifo_ok = 1'b1;
        @(posedge clk); #1;
        idle = 1'b0; send = 1'b0;
        @(negedge clk);
        chk("idle_send_ready", a_sr, 1'b1);
        chk("idle_send_oe", a_oe, 1'b0);
        @(posedge clk); #1;

        // Read timeout 70 cycles after entering RX_WAIT
        prep();
        sel = 1'b0; to_en = 1'b1; to_reg = 16'd70; write_read = 1'b0; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0; to_i = -1; n_to = 0; r0 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (s_to) begin n_to++; if (to_i < 0) to_i = i; end
            if (i == 71) r0 = s_sr;
            @(posedge clk); #1;
        end
        chk("timeout70_cycle", to_i, 70);
        chk("timeout70_cnt", n_to, 1);
        chk("timeout70_ready", r0, 1'b1);

        // Timeout_reg = 0 fires on the first RX_WAIT cycle
        prep();
        to_en = 1'b1; to_reg = 16'd0; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0; to_i = -1; n_to = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_to) begin n_to++; if (to_i < 0) to_i = i; end
            @(posedge clk); #1;
        end
        chk("timeout0_cycle", to_i, 0);
        chk("timeout0_cnt", n_to, 1);

        // Start bit wins over a coincident timeout
        prep();
        to_en = 1'b1; to_reg = 16'd5; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0; n_to = 0; r0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pin_in = (i == 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (s_to) n_to++;
            if (i == 6) r0 = s_sr;
            @(posedge clk); #1;
        end
        chk("startwins_no_timeout", n_to, 0);
        chk("startwins_busy", r0, 1'b0);

        // Idle asserted in the middle of RX_DATA
        prep();
        to_en = 1'b0; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0; n_comp = 0; r0 = 1'b1; r1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            pin_in = (i == 0) ? 1'b0 : 1'(i % 2);
            idle = (i == 12);
            @(negedge clk);
            if (s_comp) n_comp++;
            if (i == 11) r0 = s_sr;
            if (i == 13) r1 = s_sr;
            @(posedge clk); #1;
        end
        idle = 1'b0;
        chk("rxabort_busy_before", r0, 1'b0);
        chk("rxabort_ready_after", r1, 1'b1);
        chk("rxabort_no_complete", n_comp, 0);

        // Idle asserted in the middle of TX_DATA releases the pad
        prep();
        write_read = 1'b1; fifo_dat = 32'h0; fifo_ok = 1'b1; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0; r0 = 1'b0; r1 = 1'b1; r2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle = (i == 5);
            @(negedge clk);
            if (i == 4) r0 = s_oe;
            if (i == 5) r1 = s_oe;
            if (i == 5) r2 = s_pin;
            @(posedge clk); #1;
        end
        idle = 1'b0;
        chk("txabort_oe_before", r0, 1'b1);
        chk("txabort_oe_during", r1, 1'b0);
        chk("txabort_pin_during", r2, 1'b1);
        chk("txabort_ready_after", s_sr, 1'b1);

        // Asynchronous reset mid-write drops Data_oe at once
        prep();
        write_read = 1'b1; fifo_dat = 32'h0; fifo_ok = 1'b1; send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rstmid_oe_before", a_oe, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_oe", a_oe, 1'b0);
        chk("rstmid_pin", a_pin, 1'b1);
        chk("rstmid_ready", a_sr, 1'b1);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_data_phys.md
Name: sd_data_phys

Overview:
- Physical layer of the SD host DATA path, directly downstream of the data control block.
- On Send it serializes one block from the TX FIFO onto the DAT0 line, or deserializes one block from DAT0 into the RX FIFO.
- Each block carries a start bit, CRC16 and an end bit.
- Reports Serial_ready, Complete, Timeout, Crc_error and Underrun back to data control.

Parameters:
WORDS, 128, 32-bit words per block (128 = 512 bytes); legal range 1..255
CNT_W, 16, width of the timeout counter (matches Timeout_reg)

Ports:
SD_clock  in  1  sole clock; all logic on rising edge
Reset  in  1  asynchronous reset, active-low (0 = reset)
WriteRead  in  1  1 = write (host to card), 0 = read; sampled with Send
Send  in  1  start one block transfer; honoured only in IDLE
Idle  in  1  synchronous abort to IDLE, highest priority
Timeout_enable  in  1  enables the read start-bit timeout
Timeout_reg  in  16  read timeout, in SD_clock cycles
Data_from_FIFO  in  32  TX FIFO head word (show-ahead, valid while FIFO_ok=1)
FIFO_ok  in  1  TX FIFO has a word available
Data_pin_in  in  1  DAT0 input from the card
Data_pin_out  out  1  DAT0 output value
Data_oe  out  1  DAT0 output enable
Fifo_read  out  1  1-cycle pop of the TX FIFO
Data_to_FIFO  out  32  received word
Fifo_write  out  1  1-cycle push of Data_to_FIFO
Serial_ready  out  1  high only in IDLE
Complete  out  1  1-cycle pulse at the end of a block
Timeout  out  1  1-cycle pulse on read timeout
Crc_error  out  1  1-cycle pulse, coincident with Complete, on read CRC or end-bit error
Underrun  out  1  1-cycle pulse on TX FIFO empty at a word boundary

Behaviour:
- Reset values:
  - Data_pin_out=1, Data_oe=0, Serial_ready=1, Data_to_FIFO=0.
  - All pulse outputs 0; state IDLE; counters and CRC cleared.
- States: IDLE, TX_START, TX_DATA, TX_CRC, TX_END, RX_WAIT, RX_DATA, RX_CRC, RX_END.
- Idle=1 in any state:
  - Next state IDLE; Data_oe=0, Data_pin_out=1.
  - No Complete pulse; Send is ignored that cycle.
- IDLE:
  - Serial_ready=1; Data_oe=0.
  - On Send=1 the next state is TX_START if WriteRead=1, else RX_WAIT.
  - Serial_ready drops on the following cycle.
- Write path:
  - TX_START: Data_oe=1, Data_pin_out=0 for exactly 1 cycle.
    - Requires FIFO_ok=1: latch Data_from_FIFO into the shift register and pulse Fifo_read in the same cycle.
    - If FIFO_ok=0: pulse Underrun, go to IDLE.
  - TX_DATA: shift MSB first, one bit per cycle, 32*WORDS cycles.
    - On the last bit of each word except the final one, if FIFO_ok=1, latch the next word and pulse Fifo_read.
    - If FIFO_ok=0 at that point: Underrun pulse, Data_oe=0 next cycle, go to IDLE.
  - TX_CRC: 16 cycles, CRC register MSB first.
  - TX_END: 1 cycle with Data_pin_out=1. Then Complete pulses, Data_oe=0, state IDLE.
  - Total Data_oe-high time = 32*WORDS+18 cycles.
- Read path:
  - RX_WAIT: Data_oe=0; the counter increments every cycle starting at 0.
    - If Data_pin_in=0: go to RX_DATA; the start bit is not stored.
    - Else if Timeout_enable=1 and counter==Timeout_reg: pulse Timeout, go to IDLE.
    - Start bit wins if both occur in the same cycle.
    - Timeout_reg=0 with enable set gives a timeout on the first RX_WAIT cycle.
  - RX_DATA: shift in MSB first, 32*WORDS bits.
    - Each 32nd bit: the full word is on Data_to_FIFO with Fifo_write=1 on the next cycle, for 1 cycle.
    - No RX back-pressure: the RX FIFO must hold a full block.
  - RX_CRC: receive 16 bits and compare against the computed CRC.
  - RX_END: sample the end bit, then go to IDLE.
    - Complete=1 on the next cycle.
    - Crc_error=1 in the same cycle if the CRC mismatched or the end bit was 0.
- CRC:
  - CRC16-CCITT, polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000.
  - Covers data bits only, updated one bit per cycle.
  - Cleared on entry to TX_START/RX_WAIT.
- Word and bit counters:
  - Bit counter 5 bits, wraps 31 to 0 at the word boundary.
  - Word counter 8 bits; the block ends when it reaches WORDS.

Test Plan:
1. WORDS=1, FIFO_ok=1, Data_from_FIFO=0x00000000, Send=1 with WriteRead=1 -> Data_oe high 50 cycles; DAT0 = 0, then 32 zeros, then CRC 0x0000, then 1; one Fifo_read; Complete 1 cycle after the end bit.
2. WORDS=2, words 0xA5A5A5A5 then 0x0F0F0F0F -> bitstream matches the words MSB first followed by the model CRC16; Fifo_read pulses twice; Serial_ready low throughout and high again after Complete.
3. WORDS=2, FIFO_ok dropped to 0 before the second word -> Underrun pulse at the word-1 boundary; no Complete; Data_oe=0 and IDLE the next cycle.
4. Read, WORDS=1, card drives start bit, 32 zeros, CRC 0x0000, end bit 1 -> Fifo_write with Data_to_FIFO=0x00000000; Complete=1, Crc_error=0.
5. Same as 4 with the last CRC bit flipped -> Complete=1 and Crc_error=1 in the same cycle; a second run with end bit 0 gives the same result.
6. Read with Timeout_enable=1, Timeout_reg=70, Data_pin_in held 1 -> Timeout pulse 70 cycles after RX_WAIT entry; then Send again and assert Idle mid-RX_DATA -> IDLE the next cycle with no Complete; Reset=0 mid-write -> Data_oe=0 immediately.
